occupancy_door_ctrl: RTL
========================

// Module: occupancy_door_ctrl
// PURPOSE
//  Parametrised room-occupancy and door controller; successor to the fixed 10-person, 3-cycle-door design.
//  Edge-detects entry/exit requests, tracks headcount against a programmable capacity and runs a door FSM.
//  The door hold time is a parameter, and each new admission retriggers the hold.
//  Reports full, empty and rejected requests; sits between the door sensors and the room status panel.
// PARAMETERS
//  CAPACITY   10  max occupants (>=1)
//  DOOR_HOLD  3   cycles door stays open after last admission (>=1)
//  CNT_W      localparam = $clog2(CAPACITY+1); width of count/peak
//  TMR_W      localparam = $clog2(DOOR_HOLD+1); width of hold timer
// PORTS
//  clk     in   1      single clock, rising edge
//  rst     in   1      asynchronous, active-high reset
//  ent     in   1      entry request level; one admission per rising edge
//  exit    in   1      exit request level; one departure per rising edge
//  in      out  1      1-cycle pulse: door cycle completed, door closing
//  out     out  1      1-cycle pulse: exit accepted
//  open    out  1      door open (registered)
//  close   out  1      room empty (count==0)
//  full    out  1      count==CAPACITY
//  reject  out  1      1-cycle pulse: entry refused (room full)
//  count   out  CNT_W  current occupancy
//  peak    out  CNT_W  high-water mark (only with PEAK_TRACK_EN)
// BEHAVIOUR
//  Reset: count=0, open=0, in=0, out=0, reject=0, full=0, close=1, state=DOOR_IDLE, timer=0.
//   Edge-detect regs clear to 0.
//  Edges: ent_r = ent & ~ent_q; exit_r = exit & ~exit_q. Held levels give exactly one event.
//  Accept rules, evaluated on the registered count:
//   - exit_acc = exit_r & (count!=0)
//   - ent_acc  = ent_r & ((count<CAPACITY) | exit_acc)
//   - count <= count + ent_acc - exit_acc; never wraps, never exceeds CAPACITY.
//  Output pulses, registered, one cycle after the sampled edge:
//   - out = exit_acc
//   - reject = ent_r & ~ent_acc
//   - full/close follow count combinationally from the count register.
//  Door FSM:
//   - DOOR_IDLE: on ent_acc -> DOOR_OPEN, open<=1, timer<=DOOR_HOLD-1.
//   - DOOR_OPEN: ent_acc reloads timer to DOOR_HOLD-1 (door stays open).
//       Otherwise, while timer!=0, timer decrements.
//       When timer==0 with no ent_acc -> DOOR_IDLE, open<=0, in<=1 for one cycle.
//   - Open duration after the last admission: exactly DOOR_HOLD cycles.
//  Simultaneous ent & exit:
//   - Full room: both accepted, count unchanged.
//   - Empty room: exit ignored, entry accepted.
//  Exits never affect the door FSM.
//  Reset asserted mid-open: door drops immediately, no in pulse, count lost.
// CONFIGURATION
//  PEAK_TRACK_EN defined: peak port present.
//   - peak <= max(peak, count_next) each cycle; cleared only by rst.
//  PEAK_TRACK_EN undefined: peak port and its register are absent; all other behaviour is identical.
// STRUCTURE
//  Package occupancy_pkg: typedef enum door_state_t {DOOR_IDLE, DOOR_OPEN}, plus a clog2 helper function.
//  Sub-module edge_rise (1-bit rising-edge pulse, async reset), instantiated for ent and exit.
// TESTING (CAPACITY=10, DOOR_HOLD=3)
//  1. rst pulse mid-run -> count=0, close=1, open=0, full=0 during reset and after release.
//  2. ent rise sampled at edge k:
//     -> count=1 and open=1 from k+1; open=1 for 3 cycles.
//     -> in=1 and open=0 in the cycle after; close=0 from k+1.
//  3. 10 separate ent pulses, then an 11th:
//     -> full=1 after the 10th.
//     -> 11th gives reject=1 for one cycle; count stays 10.
//  4. exit pulse at count=0 -> out=0, count=0. Then ent & exit rise together -> count=1, out=0.
//  5. count=10, ent & exit rise together -> count=10, out=1, reject=0, door retriggers.
//  6. ent held high 6 cycles -> exactly 1 admission.
//     Second ent rise 2 cycles later -> open held until 3 cycles after it.
//     in pulses once; peak=2 when PEAK_TRACK_EN is defined.

Source files
------------

// File: rtl/occupancy_pkg.sv
// Shared types and helpers for the occupancy/door controller.
// Holds the door FSM state encoding and a constant-width helper.
package occupancy_pkg;

  typedef enum logic {
    DOOR_IDLE = 1'b0,
    DOOR_OPEN = 1'b1
  } door_state_t;

  // Bits needed to hold values 0..v-1; used at elaboration for count/timer widths.
  function automatic int clog2(input int v);
    int r;
    int x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r = r + 1;
      x = x >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/occupancy_door_ctrl_edge_rise.sv
// Single-bit rising-edge detector: pulse is high while d is high and was low
// on the previous clock. Asynchronous active-high reset clears the history.
module edge_rise (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic pulse
);

  logic d_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) d_q <= 1'b0;
    else     d_q <= d;
  end

  assign pulse = d & ~d_q;

endmodule

// File: rtl/occupancy_door_ctrl.sv
// Room occupancy counter with a retriggerable door-hold FSM.
// Optional high-water mark output enabled by defining PEAK_TRACK_EN.
module occupancy_door_ctrl
  import occupancy_pkg::*;
#(
  parameter  int CAPACITY  = 10,
  parameter  int DOOR_HOLD = 3,
  localparam int CNT_W     = clog2(CAPACITY + 1),
  localparam int TMR_W     = clog2(DOOR_HOLD + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ent,
  input  logic             exit,
  output logic             in,
  output logic             out,
  output logic             open,
  output logic             close,
  output logic             full,
  output logic             reject,
  output logic [CNT_W-1:0] count
`ifdef PEAK_TRACK_EN
  ,
  output logic [CNT_W-1:0] peak
`else
`endif
);

  localparam logic [CNT_W-1:0] CAP_V   = CNT_W'(CAPACITY);
  localparam logic [TMR_W-1:0] HOLD_LD = TMR_W'(DOOR_HOLD - 1);

  logic ent_r;
  logic exit_r;
  logic ent_acc;
  logic exit_acc;
  logic [CNT_W-1:0] count_next;

  door_state_t      state, state_next;
  logic [TMR_W-1:0] timer, timer_next;
  logic             open_next;
  logic             in_next;

  edge_rise u_ent_edge (
    .clk   (clk),
    .rst   (rst),
    .d     (ent),
    .pulse (ent_r)
  );

  edge_rise u_exit_edge (
    .clk   (clk),
    .rst   (rst),
    .d     (exit),
    .pulse (exit_r)
  );

  // A departure in the same cycle frees a seat, so a full room can still admit.
  assign exit_acc   = exit_r & (count != '0);
  assign ent_acc    = ent_r & ((count < CAP_V) | exit_acc);
  assign count_next = count + CNT_W'(ent_acc) - CNT_W'(exit_acc);

  assign full  = (count == CAP_V);
  assign close = (count == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count  <= '0;
      out    <= 1'b0;
      reject <= 1'b0;
    end else begin
      count  <= count_next;
      out    <= exit_acc;
      reject <= ent_r & ~ent_acc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= DOOR_IDLE;
      timer <= '0;
      open  <= 1'b0;
      in    <= 1'b0;
    end else begin
      state <= state_next;
      timer <= timer_next;
      open  <= open_next;
      in    <= in_next;
    end
  end

  // Timer counts down from DOOR_HOLD-1; the close happens on the cycle after it hits zero.
  always_comb begin
    state_next = state;
    timer_next = timer;
    open_next  = open;
    in_next    = 1'b0;
    case (state)
      DOOR_IDLE: begin
        if (ent_acc) begin
          state_next = DOOR_OPEN;
          open_next  = 1'b1;
          timer_next = HOLD_LD;
        end
      end
      DOOR_OPEN: begin
        if (ent_acc) begin
          timer_next = HOLD_LD;
        end else if (timer != '0) begin
          timer_next = timer - TMR_W'(1);
        end else begin
          state_next = DOOR_IDLE;
          open_next  = 1'b0;
          in_next    = 1'b1;
        end
      end
      default: begin
        state_next = DOOR_IDLE;
        open_next  = 1'b0;
      end
    endcase
  end

`ifdef PEAK_TRACK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    peak <= '0;
    else if (count_next > peak) peak <= count_next;
  end
`else
`endif

endmodule
